// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage core.
// Detects load-use hazards against the instruction currently in EX. On a
// hazard or a flush it loads a bubble into EX, and it counts the bubbles
// inserted for hazards.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ctl_wb,
  input  logic [2:0]  ctl_mem,
  input  logic [3:0]  ctl_ex,
  input  logic [31:0] id_npc,
  input  logic [31:0] id_rdata1,
  input  logic [31:0] id_rdata2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        flush,
  output logic [1:0]  ex_wb,
  output logic [2:0]  ex_mem,
  output logic [3:0]  ex_ex,
  output logic [31:0] ex_npc,
  output logic [31:0] ex_rdata1,
  output logic [31:0] ex_rdata2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
  output logic        stall,
  output logic [15:0] bubble_cnt
);

  logic [1:0]  r_wb;
  logic [2:0]  r_mem;
  logic [3:0]  r_ex;
  logic [31:0] r_npc;
  logic [31:0] r_rdata1;
  logic [31:0] r_rdata2;
  logic [31:0] r_imm;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;
  logic        r_valid;
  logic [15:0] r_bubble_cnt;

  logic w_hazard;
  logic w_bubble;
  logic w_hazard_bubble;

  // Hazard detection. Both source fields are compared for every opcode;
  // an occasional false stall is cheaper than decoding the format here.
  always_comb begin
    w_hazard        = r_mem[0] & r_valid & (r_rt != 5'd0) &
                      ((r_rt == id_rs) | (r_rt == id_rt));
    w_bubble        = w_hazard | flush;
    w_hazard_bubble = w_hazard & ~flush;
  end

  // Pipeline register. A bubble zeroes the control and destination fields
  // and leaves the data fields holding their previous values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb     <= '0;
      r_mem    <= '0;
      r_ex     <= '0;
      r_npc    <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_valid  <= 1'b0;
    end else if (w_bubble) begin
      r_wb    <= '0;
      r_mem   <= '0;
      r_ex    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_wb     <= ctl_wb;
      r_mem    <= ctl_mem;
      r_ex     <= ctl_ex;
      r_npc    <= id_npc;
      r_rdata1 <= id_rdata1;
      r_rdata2 <= id_rdata2;
      r_imm    <= id_imm;
      r_rt     <= id_rt;
      r_rd     <= id_rd;
      r_valid  <= 1'b1;
    end
  end

  // Saturating count of bubbles inserted for hazards. Flush bubbles are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_hazard_bubble && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign ex_wb      = r_wb;
  assign ex_mem     = r_mem;
  assign ex_ex      = r_ex;
  assign ex_npc     = r_npc;
  assign ex_rdata1  = r_rdata1;
  assign ex_rdata2  = r_rdata2;
  assign ex_imm     = r_imm;
  assign ex_rt      = r_rt;
  assign ex_rd      = r_rd;
  assign ex_valid   = r_valid;
  assign stall      = w_hazard_bubble;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table plus hand sequences for
// counter saturation and for reset arriving during a stall.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  ctl_wb;
  logic [2:0]  ctl_mem;
  logic [3:0]  ctl_ex;
  logic [31:0] id_npc, id_rdata1, id_rdata2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        flush;
  logic [1:0]  ex_wb;
  logic [2:0]  ex_mem;
  logic [3:0]  ex_ex;
  logic [31:0] ex_npc, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]  ex_rt, ex_rd;
  logic        ex_valid;
  logic        stall;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .ctl_wb(ctl_wb), .ctl_mem(ctl_mem), .ctl_ex(ctl_ex),
    .id_npc(id_npc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_wb(ex_wb), .ex_mem(ex_mem), .ex_ex(ex_ex),
    .ex_npc(ex_npc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .stall(stall), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [3:0]  ex;
    logic [31:0] npc, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        fl;
    logic        e_stall;
    logic [1:0]  e_wb;
    logic [2:0]  e_mem;
    logic [3:0]  e_ex;
    logic [31:0] e_npc, e_rd1, e_rd2, e_imm;
    logic [4:0]  e_rt, e_rd;
    logic        e_valid;
    logic [15:0] e_bub;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex,
                       input logic [31:0] npc, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic fl);
    ctl_wb = wb; ctl_mem = mem; ctl_ex = ex;
    id_npc = npc; id_rdata1 = rd1; id_rdata2 = rd2; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ex_wb"}, 32'(ex_wb), 32'd0);
    chk({tag, ".ex_mem"}, 32'(ex_mem), 32'd0);
    chk({tag, ".ex_ex"}, 32'(ex_ex), 32'd0);
    chk({tag, ".ex_npc"}, ex_npc, 32'd0);
    chk({tag, ".ex_rdata1"}, ex_rdata1, 32'd0);
    chk({tag, ".ex_rdata2"}, ex_rdata2, 32'd0);
    chk({tag, ".ex_imm"}, ex_imm, 32'd0);
    chk({tag, ".ex_rt"}, 32'(ex_rt), 32'd0);
    chk({tag, ".ex_rd"}, 32'(ex_rd), 32'd0);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'd0);
  endtask

  initial begin
    //           wb     mem     ex       npc     rd1     rd2     imm    rs  rt  rd fl | stall ewb   emem    eex      enpc    erd1     erd2    eimm   ert erd val bub
    // R-type pass-through
    vecs[0]  = '{2'b10, 3'b000, 4'b0010, 32'h04, 32'h05, 32'h07, 32'h10, 1,  2,  8, 0,  0, 2'b10, 3'b000, 4'b0010, 32'h04, 32'h05,  32'h07, 32'h10, 2,  8, 1, 16'd0};
    // LW to r9
    vecs[1]  = '{2'b11, 3'b001, 4'b0000, 32'h08, 32'h100, 32'h0, 32'h04, 3,  9,  0, 0,  0, 2'b11, 3'b001, 4'b0000, 32'h08, 32'h100, 32'h0,  32'h04, 9,  0, 1, 16'd0};
    // consumer reads r9 through rs: stall, bubble, data held
    vecs[2]  = '{2'b10, 3'b000, 4'b0010, 32'h0C, 32'hAA, 32'hBB, 32'h00, 9,  4, 10, 0,  1, 2'b00, 3'b000, 4'b0000, 32'h08, 32'h100, 32'h0,  32'h04, 0,  0, 0, 16'd1};
    // same consumer re-presented: latches normally
    vecs[3]  = '{2'b10, 3'b000, 4'b0010, 32'h0C, 32'hAA, 32'hBB, 32'h00, 9,  4, 10, 0,  0, 2'b10, 3'b000, 4'b0010, 32'h0C, 32'hAA,  32'hBB, 32'h00, 4, 10, 1, 16'd1};
    // LW to r0
    vecs[4]  = '{2'b11, 3'b001, 4'b0000, 32'h10, 32'h200, 32'h0, 32'h08, 5,  0,  0, 0,  0, 2'b11, 3'b001, 4'b0000, 32'h10, 32'h200, 32'h0,  32'h08, 0,  0, 1, 16'd1};
    // reader of r0: never a hazard
    vecs[5]  = '{2'b10, 3'b000, 4'b0010, 32'h14, 32'h01, 32'h02, 32'h03, 0,  0, 11, 0,  0, 2'b10, 3'b000, 4'b0010, 32'h14, 32'h01,  32'h02, 32'h03, 0, 11, 1, 16'd1};
    // LW to r12
    vecs[6]  = '{2'b11, 3'b001, 4'b0000, 32'h18, 32'h300, 32'h0, 32'h0C, 6, 12,  0, 0,  0, 2'b11, 3'b001, 4'b0000, 32'h18, 32'h300, 32'h0,  32'h0C, 12, 0, 1, 16'd1};
    // hazard through rt but flush wins: no stall, bubble, count unchanged
    vecs[7]  = '{2'b10, 3'b010, 4'b0001, 32'h1C, 32'h05, 32'h06, 32'h07, 1, 12, 13, 1,  0, 2'b00, 3'b000, 4'b0000, 32'h18, 32'h300, 32'h0,  32'h0C, 0,  0, 0, 16'd1};
    // unknown opcode, all control zero: ordinary valid instruction
    vecs[8]  = '{2'b00, 3'b000, 4'b0000, 32'h20, 32'h11, 32'h22, 32'h33, 12, 12, 14, 0, 0, 2'b00, 3'b000, 4'b0000, 32'h20, 32'h11,  32'h22, 32'h33, 12, 14, 1, 16'd1};
    // SW with rt=15
    vecs[9]  = '{2'b00, 3'b010, 4'b0000, 32'h24, 32'h01, 32'h02, 32'h03, 12, 15, 0, 0,  0, 2'b00, 3'b010, 4'b0000, 32'h24, 32'h01,  32'h02, 32'h03, 15, 0, 1, 16'd1};
    // reader of r15 behind a store: no hazard
    vecs[10] = '{2'b10, 3'b000, 4'b0010, 32'h28, 32'h04, 32'h05, 32'h06, 15, 15, 16, 0, 0, 2'b10, 3'b000, 4'b0010, 32'h28, 32'h04,  32'h05, 32'h06, 15, 16, 1, 16'd1};
    // plain flush
    vecs[11] = '{2'b11, 3'b001, 4'b0000, 32'h2C, 32'h09, 32'h09, 32'h09, 1, 20,  0, 1,  0, 2'b00, 3'b000, 4'b0000, 32'h28, 32'h04,  32'h05, 32'h06, 0,  0, 0, 16'd1};

    // reset
    rst = 1'b1;
    drive(2'b11, 3'b111, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 5'd1, 5'd1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 3'b000, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("reset.stall", 32'(stall), 32'd0);

    // vector table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].wb, vecs[i].mem, vecs[i].ex, vecs[i].npc, vecs[i].rd1, vecs[i].rd2,
            vecs[i].imm, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].fl);
      #1;
      chk($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.ex_wb", i), 32'(ex_wb), 32'(vecs[i].e_wb));
      chk($sformatf("v%0d.ex_mem", i), 32'(ex_mem), 32'(vecs[i].e_mem));
      chk($sformatf("v%0d.ex_ex", i), 32'(ex_ex), 32'(vecs[i].e_ex));
      chk($sformatf("v%0d.ex_npc", i), ex_npc, vecs[i].e_npc);
      chk($sformatf("v%0d.ex_rdata1", i), ex_rdata1, vecs[i].e_rd1);
      chk($sformatf("v%0d.ex_rdata2", i), ex_rdata2, vecs[i].e_rd2);
      chk($sformatf("v%0d.ex_imm", i), ex_imm, vecs[i].e_imm);
      chk($sformatf("v%0d.ex_rt", i), 32'(ex_rt), 32'(vecs[i].e_rt));
      chk($sformatf("v%0d.ex_rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d.ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d.bubble_cnt", i), 32'(bubble_cnt), 32'(vecs[i].e_bub));
    end

    // saturation: preload near the top, then three load-use pairs
    @(negedge clk);
    drive(2'b00, 3'b000, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    force dut.r_bubble_cnt = 16'hFFFD;
    @(posedge clk);
    @(negedge clk);
    release dut.r_bubble_cnt;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] exp_cnt;
      exp_cnt = (k == 0) ? 16'hFFFE : 16'hFFFF;
      drive(2'b11, 3'b001, 4'h0, 32'h40, 32'h0, 32'h0, 32'h0, 5'd1, 5'd9, 5'd0, 1'b0);
      @(negedge clk);
      drive(2'b10, 3'b000, 4'h2, 32'h44, 32'h0, 32'h0, 32'h0, 5'd9, 5'd2, 5'd3, 1'b0);
      #1;
      chk($sformatf("sat%0d.stall", k), 32'(stall), 32'd1);
      @(negedge clk);
      chk($sformatf("sat%0d.bubble_cnt", k), 32'(bubble_cnt), 32'(exp_cnt));
    end

    // reset arriving in a stall cycle: load via rt, reset on the stall edge
    drive(2'b11, 3'b001, 4'h0, 32'h50, 32'h55, 32'h66, 32'h77, 5'd1, 5'd7, 5'd0, 1'b0);
    @(negedge clk);
    drive(2'b10, 3'b000, 4'h2, 32'h54, 32'h1, 32'h2, 32'h3, 5'd2, 5'd7, 5'd4, 1'b0);
    rst = 1'b1;
    #1;
    chk("rststall.stall_before", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    chk_all_zero("rststall");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rststall.stall_after", 32'(stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL be clocked by a single clock and SHALL use a synchronous, active-high reset; clock and reset are the first two ports.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 ctl_wb  input  2  write-back control from decode control unit ([1]=RegWrite, [0]=MemToReg).
REQ-005 ctl_mem  input  3  memory control from decode ([2]=Branch, [1]=MemWrite, [0]=MemRead).
REQ-006 ctl_ex  input  4  execute/ALU control from decode.
REQ-007 id_npc, id_rdata1, id_rdata2, id_imm  input  32 each  next PC, register-file reads, sign-extended immediate.
REQ-008 id_rs, id_rt, id_rd  input  5 each  instruction register fields [25:21], [20:16], [15:11].
REQ-009 flush  input  1  squash request from branch resolution (taken branch).
REQ-010 ex_wb, ex_mem, ex_ex  output  2/3/4  registered control to EX stage.
REQ-011 ex_npc, ex_rdata1, ex_rdata2, ex_imm  output  32 each  registered data to EX stage.
REQ-012 ex_rt, ex_rd  output  5 each  registered destination candidates.
REQ-013 ex_valid  output  1  registered: EX slot holds a real instruction.
REQ-014 stall  output  1  combinational: hold PC and IF/ID register this cycle.
REQ-015 bubble_cnt  output  16  registered count of inserted bubbles, saturating.

Function
REQ-016 hazard SHALL be defined as ex_mem[0]=1 AND ex_valid=1 AND ex_rt!=0 AND (ex_rt==id_rs OR ex_rt==id_rt); comparison on both fields regardless of instruction type (conservative false stalls accepted).
REQ-017 stall SHALL equal hazard AND NOT flush.
REQ-018 Normal cycle (no flush, no hazard): all ex_* outputs SHALL take the corresponding id_*/ctl_* inputs on the next edge, ex_valid<=1; latency exactly one cycle.
REQ-019 Hazard cycle (hazard=1, flush=0): ex_wb, ex_mem, ex_ex SHALL be loaded with zero, ex_valid<=0, ex_rt<=0, ex_rd<=0; ex_npc, ex_rdata1, ex_rdata2, ex_imm SHALL hold their previous values.
REQ-020 Flush cycle (flush=1): identical load to REQ-019 regardless of hazard; flush has priority over hazard.
REQ-021 Because a bubble clears ex_mem[0] and ex_valid, a single load-use hazard SHALL produce exactly one stall cycle; stall SHALL never assert in two consecutive cycles for the same load.
REQ-022 bubble_cnt SHALL increment by 1 on each edge where REQ-019 applies (hazard bubbles only, not flushes), saturating at 16'hFFFF with no wrap.
REQ-023 Register fields are 5 bits; register 0 SHALL never cause a hazard.
REQ-024 Decode-unit default (unknown opcode, all control zero) SHALL pass through as an ordinary instruction with ex_valid=1 and zero control.

Reset
REQ-025 On a rising edge with rst=1 all registered outputs (ex_wb, ex_mem, ex_ex, ex_npc, ex_rdata1, ex_rdata2, ex_imm, ex_rt, ex_rd, ex_valid, bubble_cnt) SHALL become 0; rst overrides flush and hazard.
REQ-026 stall SHALL be 0 in the first cycle after reset (follows from ex_valid=0).
REQ-027 Reset asserted mid-stall SHALL discard the stalled instruction; no bubble_cnt increment on that edge.

Verification
REQ-028 R-type pass-through: ctl_wb=2'b10, ctl_mem=0, ctl_ex=4'b0010, id_rdata1=32'h0000_0005, id_rd=5'd8 -> next cycle ex_wb=2'b10, ex_ex=4'b0010, ex_rdata1=5, ex_rd=8, ex_valid=1, stall=0.
REQ-029 Load-use: LW latched with ex_rt=5'd9, ex_mem=3'b001; next decode id_rs=5'd9 -> stall=1 that cycle; next edge ex_wb=0, ex_mem=0, ex_ex=0, ex_valid=0, bubble_cnt=1; following cycle stall=0 and the held instruction latches normally.
REQ-030 Register-zero: LW with ex_rt=0, id_rs=0 -> stall=0, no bubble.
REQ-031 Flush with hazard: hazard condition true and flush=1 -> stall=0, bubble loaded, bubble_cnt unchanged.
REQ-032 Saturation: preload 16'hFFFE by 3 forced hazards after suitable sequence (or force) -> counter reads 16'hFFFF and stays 16'hFFFF on further hazards.
REQ-033 Reset mid-stall: hazard active, rst=1 on same edge -> all outputs 0, bubble_cnt=0, stall=0 next cycle.
